// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memEN/RW/MFC bus: state encodings, RW polarity, wait counter width.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM; read data is registered and held until the next read.
module mem_responder_mem_array #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the memEN/RW/MFC four-phase bus with WAIT_CYCLES wait states.
// Optional write protection of addresses 0..RO_TOP is enabled by defining MEM_WRPROT_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 16,
  parameter int unsigned WAIT_CYCLES = 2
`ifdef MEM_WRPROT_EN
  ,
  parameter int unsigned RO_TOP      = 15
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memEN,
  input  logic          RW,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          MFC,
  output logic          busy
`ifdef MEM_WRPROT_EN
  ,
  output logic          memErr
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mfc_q, mfc_d;
  logic             busy_q, busy_d;
  logic             commit_c;
  logic             ram_we_c;
  logic             ram_re_c;

  // The access completes on the WAIT edge where the counter has run out and memEN is still held.
  assign commit_c = (state_q == ST_WAIT) && memEN && (cnt_q == '0);
  assign ram_re_c = commit_c && (RW == RW_READ);

`ifdef MEM_WRPROT_EN
  logic wr_blocked_c;
  logic err_q, err_d;

  assign wr_blocked_c = (RW == RW_WRITE) && (addr <= AW'(RO_TOP));
  assign ram_we_c     = commit_c && (RW == RW_WRITE) && !wr_blocked_c;

  // Error flag is captured at commit and lives exactly as long as DONE.
  always_comb begin
    err_d = 1'b0;
    if (state_d == ST_DONE) begin
      err_d = commit_c ? wr_blocked_c : err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign memErr = err_q;
`else
  assign ram_we_c = commit_c && (RW == RW_WRITE);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (memEN) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        end
      end
      ST_WAIT: begin
        if (!memEN) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!memEN) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    mfc_d  = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mfc_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mfc_q   <= mfc_d;
      busy_q  <= busy_d;
    end
  end

  assign MFC  = mfc_q;
  assign busy = busy_q;

  mem_responder_mem_array #(
    .AW (AW),
    .DW (DW)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we_c),
    .re    (ram_re_c),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

endmodule
